imem_loader: RTL and testbench

Boot-time program loader for the single-cycle MIPS core. It accepts a framed byte stream on a valid/ready interface, packs the bytes big-endian into 32-bit instruction words, and writes them into instruction memory starting at the core's reset PC. It verifies a trailing XOR checksum, then either releases the core via `cpu_run` or latches an error. It is the writer side of the instruction-memory interface that the core's fetch path only reads.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/word_assembler.sv | 32 +++
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: reset PC, frame widths
// and the boot loader state encoding.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;
  localparam int CSUM_W = 8;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_CNT_HI = 3'd1,
    LD_CNT_LO = 3'd2,
    LD_DATA   = 3'd3,
    LD_CSUM   = 3'd4,
    LD_DONE   = 3'd5,
    LD_ERR    = 3'd6
  } ld_state_e;

endpackage

// File: rtl/word_assembler.sv
// Packs payload bytes big-endian into 32-bit words;
// word_valid flags the handshake of each 4th byte.
module word_assembler
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [WORD_W-BYTE_W-1:0] shift;
  logic [1:0]               cnt;

  // Shift in accepted bytes and count position in the word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift <= '0;
      cnt   <= '0;
    end else if (byte_en) begin
      shift <= {shift[WORD_W-2*BYTE_W-1:0], byte_in};
      cnt   <= cnt + 2'd1;
    end
  end

  // The 4th byte completes the word without waiting a cycle
  assign word       = {shift, byte_in};
  assign word_valid = byte_en && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> instruction memory,
// checksum verified before the core is released.
module imem_loader
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = RESET_PC,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [31:0]       im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_err,
  output logic [CNT_W-1:0]  words_loaded
);

  ld_state_e          state;
  ld_state_e          state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CSUM_W-1:0]  csum;
  logic [CNT_W-1:0]   wl;
  logic               hs;
  logic [CNT_W-1:0]   n_full;
  logic               byte_en;
  logic [WORD_W-1:0]  word;
  logic               word_valid;
  logic               last_word;

  assign hs      = rx_valid && rx_ready;
  assign n_full  = {cnt[15:8], rx_data};
  assign byte_en = hs && (state == LD_DATA);

  // The final word of the payload ends the data phase
  assign last_word = word_valid && ((wl + 16'd1) == cnt);

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_en    (byte_en),
    .byte_in    (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= LD_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and stream readiness
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    unique case (state)
      LD_IDLE: state_nxt = LD_CNT_HI;
      LD_CNT_HI: begin
        rx_ready = 1'b1;
        if (hs) state_nxt = LD_CNT_LO;
      end
      LD_CNT_LO: begin
        rx_ready = 1'b1;
        if (hs) begin
          if ({16'd0, n_full} > MAX_WORDS)
            state_nxt = LD_ERR;
          else if (n_full == '0)
            state_nxt = LD_CSUM;
          else
            state_nxt = LD_DATA;
        end
      end
      LD_DATA: begin
        rx_ready = 1'b1;
        if (last_word) state_nxt = LD_CSUM;
      end
      LD_CSUM: begin
        rx_ready = 1'b1;
        if (hs)
          state_nxt = (rx_data == csum) ? LD_DONE
                                        : LD_ERR;
      end
      LD_DONE: state_nxt = LD_DONE;
      LD_ERR:  state_nxt = LD_ERR;
      default: state_nxt = LD_IDLE;
    endcase
  end

  // Capture the word count, high byte first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (hs) begin
      if (state == LD_CNT_HI) cnt[15:8] <= rx_data;
      if (state == LD_CNT_LO) cnt[7:0]  <= rx_data;
    end
  end

  // Running XOR over payload bytes only
  always_ff @(posedge clk) begin
    if (!rst_n)       csum <= '0;
    else if (byte_en) csum <= csum ^ rx_data;
  end

  // Registered memory write port and word counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      wl       <= '0;
    end else begin
      im_we <= word_valid;
      if (word_valid) begin
        im_wdata <= word;
        im_addr  <= BASE_ADDR + {14'd0, wl, 2'b00};
        wl       <= wl + 16'd1;
      end
    end
  end

  assign words_loaded = wl;
  assign cpu_run      = (state == LD_DONE);
  assign load_done    = (state == LD_DONE);
  assign load_err     = (state == LD_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame table,
// write scoreboard and hand-written corner sequences.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int MAXW = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        cpu_run;
  logic        load_done;
  logic        load_err;
  logic [15:0] words_loaded;

  imem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_run      (cpu_run),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    string       name;
    logic [95:0] p;
    int          len;
    bit          thr;
    logic        done;
    logic        err;
    logic [15:0] nw;
  } vec_t;

  wr_t        exp_q[$];
  logic [7:0] frame[$];
  vec_t       tbl[6];
  int         nvec = 0;
  int         nmis = 0;
  int         nwr  = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Scoreboard: every write must match the next expected one
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      nwr++;
      if (exp_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_write: got %h@%h expected none",
                 im_wdata, im_addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", im_addr, e.a);
        check("write_data", im_wdata, e.d);
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_ready}, 0);
    check("rst_im_we", {31'd0, im_we}, 0);
    check("rst_im_addr", im_addr, 0);
    check("rst_im_wdata", im_wdata, 0);
    check("rst_cpu_run", {31'd0, cpu_run}, 0);
    check("rst_done", {31'd0, load_done}, 0);
    check("rst_err", {31'd0, load_err}, 0);
    check("rst_words", {16'd0, words_loaded}, 0);
    exp_q.delete();
    nwr   = 0;
    rst_n = 1'b1;
    check("idle_rx_ready", {31'd0, rx_ready}, 0);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input bit thr,
                           input bit exp_we);
    int t;
    t = 0;
    if (thr) begin
      repeat ($urandom_range(1, 3)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      nvec++;
      nmis++;
      $display("FAIL ready_timeout: got 0 expected 1");
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    check("we_timing", {31'd0, im_we}, {31'd0, exp_we});
  endtask

  task automatic load_frame(input logic [95:0] p,
                            input int len);
    frame.delete();
    for (int i = 0; i < len; i++)
      frame.push_back(p[95-8*i -: 8]);
  endtask

  // Sends bytes [0, upto) of the frame, modelling writes
  task automatic run_frame(input bit thr, input int upto);
    int          n;
    int          widx;
    bit          is_data;
    bit          exp_we;
    logic [31:0] w;
    n    = int'({frame[0], frame[1]});
    widx = 0;
    w    = '0;
    for (int i = 0; i < upto; i++) begin
      is_data = (i >= 2) && (i < frame.size() - 1)
                && (n <= MAXW);
      exp_we  = is_data && (((i - 2) % 4) == 3);
      if (is_data) w = {w[23:0], frame[i]};
      if (exp_we) begin
        exp_q.push_back({BASE + 32'(4 * widx), w});
        widx++;
      end
      send_byte(frame[i], thr, exp_we);
    end
  endtask

  task automatic final_check(input string nm,
                             input logic done,
                             input logic err,
                             input logic [15:0] nw);
    check({nm, "_cpu_run"}, {31'd0, cpu_run}, {31'd0, done});
    check({nm, "_done"}, {31'd0, load_done}, {31'd0, done});
    check({nm, "_err"}, {31'd0, load_err}, {31'd0, err});
    check({nm, "_words"}, {16'd0, words_loaded}, {16'd0, nw});
    check({nm, "_rx_ready"}, {31'd0, rx_ready}, 0);
    check({nm, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0]  cs;
    logic [31:0] w;

    tbl[0] = '{"good", 96'h0002_2008_0005_2009_000A_0E00,
               11, 1'b0, 1'b1, 1'b0, 16'd2};
    tbl[1] = '{"badcs", 96'h0002_2008_0005_2009_000A_FF00,
               11, 1'b0, 1'b0, 1'b1, 16'd2};
    tbl[2] = '{"empty", 96'h0000_0000_0000_0000_0000_0000,
               3, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[3] = '{"ovf", 96'h0101_0000_0000_0000_0000_0000,
               2, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[4] = '{"throttle", 96'h0002_2008_0005_2009_000A_0E00,
               11, 1'b1, 1'b1, 1'b0, 16'd2};
    tbl[5] = '{"one", 96'h0001_DEAD_BEEF_2200_0000_0000,
               7, 1'b1, 1'b1, 1'b0, 16'd1};

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      load_frame(tbl[v].p, tbl[v].len);
      run_frame(tbl[v].thr, frame.size());
      final_check(tbl[v].name, tbl[v].done,
                  tbl[v].err, tbl[v].nw);
      if (v == 3) begin
        for (int k = 0; k < 6; k++) begin
          rx_valid = 1'b1;
          rx_data  = 8'(k);
          @(negedge clk);
          check("ovf_ignore_ready", {31'd0, rx_ready}, 0);
          check("ovf_ignore_we", {31'd0, im_we}, 0);
        end
        rx_valid = 1'b0;
        final_check("ovf_after", 1'b0, 1'b1, 16'd0);
      end
    end

    // Reset after 7 bytes: one word written, then a clean reload
    do_reset();
    load_frame(tbl[0].p, tbl[0].len);
    run_frame(1'b0, 7);
    check("mid_writes", nwr, 1);
    check("mid_words", {16'd0, words_loaded}, 1);
    check("mid_pending", exp_q.size(), 0);
    do_reset();
    run_frame(1'b0, frame.size());
    final_check("mid_reload", 1'b1, 1'b0, 16'd2);

    // Largest legal frame: MAX_WORDS words
    do_reset();
    frame.delete();
    frame.push_back(8'h01);
    frame.push_back(8'h00);
    cs = 8'h00;
    for (int i = 0; i < MAXW; i++) begin
      w = {8'(i), 8'h5A, ~8'(i), 8'hC3};
      for (int j = 3; j >= 0; j--) begin
        frame.push_back(w[8*j +: 8]);
        cs = cs ^ w[8*j +: 8];
      end
    end
    frame.push_back(cs);
    run_frame(1'b0, frame.size());
    check("max_nwr", nwr, MAXW);
    final_check("max", 1'b1, 1'b0, 16'd256);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
